wb_ctl_pipe: RTL and testbench



---
 rtl/rv32_pkg.sv | 45 ++++
 rtl/wb_decode.sv | 66 ++++++
 rtl/wb_ctl_pipe.sv | 114 +++++++++++
 tb/tb_wb_ctl_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : RV32 opcodes, writeback-select encodings and the pipeline
//                stage record used by the writeback-control pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    // Major opcodes, instruction[6:0]
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Writeback mux select encodings
    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_CSR = 2'b11;

    // Stage-record field widths
    localparam int unsigned WB_SEL_W  = 2;
    localparam int unsigned RD_ADDR_W = 5;
    localparam int unsigned INSTR_W   = 32;

    // One pipeline stage worth of writeback control
    typedef struct packed {
        logic                 valid;
        logic [WB_SEL_W-1:0]  wb_sel;
        logic                 we;
        logic [RD_ADDR_W-1:0] rd_addr;
        logic [INSTR_W-1:0]   instr;
        logic                 illegal;
    } stage_t;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/wb_decode.sv
`default_nettype none
// ============================================================================
//  Module      : wb_decode
//  Description : Combinational decode of an RV32 instruction word into
//                writeback controls {wb_sel, we, rd_addr, illegal}.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_decode
    import rv32_pkg::*;
#(
    parameter bit CSR_EN = 1'b0
) (
    input  logic [INSTR_W-1:0]   instr_i,
    output logic [WB_SEL_W-1:0]  wb_sel_o,
    output logic                 we_o,
    output logic [RD_ADDR_W-1:0] rd_addr_o,
    output logic                 illegal_o
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;

    assign w_opcode  = instr_i[6:0];
    assign w_funct3  = instr_i[14:12];
    assign rd_addr_o = instr_i[11:7];

    // Opcode table; writes to x0 are suppressed after the table lookup
    always_comb begin
        wb_sel_o  = WB_MEM;
        we_o      = 1'b0;
        illegal_o = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: begin
                wb_sel_o = WB_ALU;
                we_o     = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                wb_sel_o = WB_PC4;
                we_o     = 1'b1;
            end
            OPC_LOAD: begin
                wb_sel_o = WB_MEM;
                we_o     = 1'b1;
            end
            OPC_STORE, OPC_BRANCH, OPC_FENCE: begin
                wb_sel_o = WB_MEM;
                we_o     = 1'b0;
            end
            OPC_SYSTEM: begin
                // funct3==0 is ECALL/EBREAK/xRET: no register result
                if (CSR_EN && (w_funct3 != 3'd0)) begin
                    wb_sel_o = WB_CSR;
                    we_o     = 1'b1;
                end
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
        if (instr_i[11:7] == 5'd0) begin
            we_o = 1'b0;
        end
    end

endmodule : wb_decode
`default_nettype wire

// File: rtl/wb_ctl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : wb_ctl_pipe
//  Description : Writeback-control pipeline. Decodes instructions and carries
//                the controls through STAGES registers (1..4) to line up with
//                the register-file write port. Supports stall, flush and a
//                wrapping retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_ctl_pipe
    import rv32_pkg::*;
#(
    parameter int STAGES = 2,
    parameter bit CSR_EN = 1'b0,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [INSTR_W-1:0]   instruction,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [WB_SEL_W-1:0]  wb_sel,
    output logic                 rd_we,
    output logic [RD_ADDR_W-1:0] rd_addr,
    output logic [INSTR_W-1:0]   instr_wb,
    output logic                 illegal,
    output logic [CNT_W-1:0]     retire_cnt
);

    logic [WB_SEL_W-1:0]  w_dec_wb_sel;
    logic                 w_dec_we;
    logic [RD_ADDR_W-1:0] w_dec_rd_addr;
    logic                 w_dec_illegal;
    stage_t               w_in_rec;
    stage_t               w_last;
    logic                 w_retire;
    logic [CNT_W-1:0]     cnt_d;
    logic [CNT_W-1:0]     cnt_q;

    wb_decode #(
        .CSR_EN (CSR_EN)
    ) u_decode (
        .instr_i   (instruction),
        .wb_sel_o  (w_dec_wb_sel),
        .we_o      (w_dec_we),
        .rd_addr_o (w_dec_rd_addr),
        .illegal_o (w_dec_illegal)
    );

    assign w_in_rec = '{
        valid:   in_valid,
        wb_sel:  w_dec_wb_sel,
        we:      w_dec_we,
        rd_addr: w_dec_rd_addr,
        instr:   instruction,
        illegal: w_dec_illegal
    };

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t stage_d;
        stage_t stage_q;

        if (k == 0) begin : g_first
            assign stage_d = w_in_rec;
        end else begin : g_chain
            assign stage_d = g_stage[k-1].stage_q;
        end

        // Stage register: reset/flush clear, stall holds, otherwise shift
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                stage_q <= '0;
            end else if (!stall) begin
                stage_q <= stage_d;
            end
        end
    end

    assign w_last = g_stage[STAGES-1].stage_q;

    // Controls are gated by valid so an empty slot can never write the RF
    assign out_valid = w_last.valid;
    assign wb_sel    = w_last.valid ? w_last.wb_sel : WB_MEM;
    assign rd_we     = w_last.valid & w_last.we;
    assign illegal   = w_last.valid & w_last.illegal;
    assign rd_addr   = w_last.rd_addr;
    assign instr_wb  = w_last.instr;

    // An instruction retires when it leaves the writeback stage
    assign w_retire = w_last.valid & ~stall & ~flush;

    // Next retire count; wraps naturally at 2^CNT_W
    always_comb begin
        cnt_d = cnt_q;
        if (w_retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Retire counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;

endmodule : wb_ctl_pipe
`default_nettype wire

// File: tb/tb_wb_ctl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_ctl_pipe
//  Description : Scoreboard bench for wb_ctl_pipe. Two instances share the
//                stimulus: A (CSR_EN=1, CNT_W=32) and B (CSR_EN=0, CNT_W=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ctl_pipe;

    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instruction;
    logic        stall;
    logic        flush;

    logic        ov_a, ov_b;
    logic [1:0]  ws_a, ws_b;
    logic        we_a, we_b;
    logic [4:0]  ra_a, ra_b;
    logic [31:0] iw_a, iw_b;
    logic        il_a, il_b;
    logic [31:0] rc_a;
    logic [1:0]  rc_b;

    wb_ctl_pipe #(.STAGES(STAGES), .CSR_EN(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
        .stall(stall), .flush(flush), .out_valid(ov_a), .wb_sel(ws_a),
        .rd_we(we_a), .rd_addr(ra_a), .instr_wb(iw_a), .illegal(il_a),
        .retire_cnt(rc_a)
    );

    wb_ctl_pipe #(.STAGES(STAGES), .CSR_EN(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
        .stall(stall), .flush(flush), .out_valid(ov_b), .wb_sel(ws_b),
        .rd_we(we_b), .rd_addr(ra_b), .instr_wb(iw_b), .illegal(il_b),
        .retire_cnt(rc_b)
    );

    always #5 clk = ~clk;

    // Scoreboard entry: instruction, advancing edges seen, expected
    // {wb_sel, we, illegal} for each instance
    typedef struct {
        logic [31:0] ins;
        int          age;
        logic [3:0]  ea;
        logic [3:0]  eb;
    } ent_t;

    ent_t        q[$];
    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] cnt_a;
    logic [1:0]  cnt_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode: returns {wb_sel, we, illegal}
    function automatic logic [3:0] ref_ctl(input logic [31:0] ins, input bit csr);
        logic [1:0] s;
        logic       w;
        logic       il;
        s = 2'b00; w = 1'b0; il = 1'b0;
        case (ins[6:0])
            7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: begin s = 2'b01; w = 1'b1; end
            7'b1101111, 7'b1100111:                         begin s = 2'b10; w = 1'b1; end
            7'b0000011:                                     begin s = 2'b00; w = 1'b1; end
            7'b0100011, 7'b1100011, 7'b0001111:             begin s = 2'b00; w = 1'b0; end
            7'b1110011: if (csr && ins[14:12] != 3'd0)      begin s = 2'b11; w = 1'b1; end
            default:                                        il = 1'b1;
        endcase
        if (ins[11:7] == 5'd0) w = 1'b0;
        return {s, w, il};
    endfunction

    task automatic cmp_one(input string p, input bit ev, input logic [3:0] ec,
                           input logic [31:0] ei, input logic ov, input logic [1:0] ws,
                           input logic we, input logic [4:0] ra, input logic [31:0] iw,
                           input logic il);
        chk({p, "_out_valid"}, 64'(ov), 64'(ev));
        if (ev) begin
            chk({p, "_wb_sel"},   64'(ws), 64'(ec[3:2]));
            chk({p, "_rd_we"},    64'(we), 64'(ec[1]));
            chk({p, "_rd_addr"},  64'(ra), 64'(ei[11:7]));
            chk({p, "_instr_wb"}, 64'(iw), 64'(ei));
            chk({p, "_illegal"},  64'(il), 64'(ec[0]));
        end else begin
            chk({p, "_gate_wb_sel"},  64'(ws), 64'd0);
            chk({p, "_gate_rd_we"},   64'(we), 64'd0);
            chk({p, "_gate_illegal"}, 64'(il), 64'd0);
        end
    endtask

    // One clock: drive inputs, compare outputs before the edge, update model
    task automatic step(input bit r, input bit v, input logic [31:0] ins,
                        input bit st, input bit fl);
        bit   ev;
        ent_t f;
        rst = r; in_valid = v; instruction = ins; stall = st; flush = fl;
        ev = (q.size() > 0) && (q[0].age == STAGES);
        f  = '{ins: 32'd0, age: 0, ea: 4'd0, eb: 4'd0};
        if (ev) f = q[0];
        cmp_one("a", ev, f.ea, f.ins, ov_a, ws_a, we_a, ra_a, iw_a, il_a);
        cmp_one("b", ev, f.eb, f.ins, ov_b, ws_b, we_b, ra_b, iw_b, il_b);
        chk("a_retire_cnt", 64'(rc_a), 64'(cnt_a));
        chk("b_retire_cnt", 64'(rc_b), 64'(cnt_b));
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            cnt_a = '0;
            cnt_b = '0;
        end else if (fl) begin
            q.delete();
        end else if (!st) begin
            if (ev) begin
                void'(q.pop_front());
                cnt_a = cnt_a + 32'd1;
                cnt_b = cnt_b + 2'd1;
            end
            foreach (q[i]) q[i].age = q[i].age + 1;
            if (v) q.push_back('{ins: ins, age: 1, ea: ref_ctl(ins, 1'b1), eb: ref_ctl(ins, 1'b0)});
        end
        rst = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins);
        step(1'b0, 1'b1, ins, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    // Run idle cycles until the scoreboard empties, bounded
    task automatic drain();
        for (int i = 0; i < 12 && q.size() > 0; i++) idle();
        idle();
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    task automatic zero_checks(input string p);
        chk({p, "_a_valid"},   64'(ov_a), 64'd0);
        chk({p, "_a_wb_sel"},  64'(ws_a), 64'd0);
        chk({p, "_a_rd_we"},   64'(we_a), 64'd0);
        chk({p, "_a_rd_addr"}, 64'(ra_a), 64'd0);
        chk({p, "_a_instr"},   64'(iw_a), 64'd0);
        chk({p, "_a_illegal"}, 64'(il_a), 64'd0);
        chk({p, "_a_cnt"},     64'(rc_a), 64'd0);
        chk({p, "_b_valid"},   64'(ov_b), 64'd0);
        chk({p, "_b_rd_addr"}, 64'(ra_b), 64'd0);
        chk({p, "_b_instr"},   64'(iw_b), 64'd0);
        chk({p, "_b_cnt"},     64'(rc_b), 64'd0);
    endtask

    logic [6:0] opc_tab [14];

    initial begin
        opc_tab = '{7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b1101111,
                    7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0001111,
                    7'b1110011, 7'b1111111, 7'b0000000, 7'b0101011};
        cnt_a = '0; cnt_b = '0;
        rst = 1'b1; in_valid = 1'b0; instruction = 32'd0; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        zero_checks("reset");

        // ADDI x5,x0,1: visible two edges after accept, then retires
        issue(32'h00100293);
        idle();
        chk("addi_valid_at_2", 64'(ov_a), 64'd1);
        chk("addi_rd_addr", 64'(ra_a), 64'd5);
        idle();
        chk("addi_cnt", 64'(rc_a), 64'd1);
        drain();

        // Back-to-back JAL, SW, NOP
        issue(32'h008000EF);
        issue(32'h00502023);
        issue(32'h00000013);
        drain();
        chk("b2b_cnt", 64'(rc_a), 64'd4);

        // Stall 3 cycles with two in flight; ignored input during stall
        issue(32'h00100313);
        issue(32'h00200393);
        repeat (3) step(1'b0, 1'b1, 32'h00300413, 1'b1, 1'b0);
        drain();
        chk("stall_cnt", 64'(rc_a), 64'd6);

        // Flush with stall while two in flight
        issue(32'h00400493);
        issue(32'h00500513);
        step(1'b0, 1'b1, 32'h00600593, 1'b1, 1'b1);
        chk("flush_valid", 64'(ov_a), 64'd0);
        chk("flush_rd_we", 64'(we_a), 64'd0);
        drain();
        chk("flush_cnt", 64'(rc_a), 64'd6);

        // CSRRW x3,mstatus,x1 on both CSR_EN settings
        issue(32'h300091F3);
        idle();
        chk("csr_a_wb_sel", 64'(ws_a), 64'd3);
        chk("csr_b_wb_sel", 64'(ws_b), 64'd0);
        chk("csr_b_rd_we",  64'(we_b), 64'd0);
        drain();

        // Preload narrow counter to 3, then retire an illegal word to wrap
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        zero_checks("rst2");
        repeat (3) issue(32'h00100293);
        drain();
        chk("wrap_pre", 64'(rc_b), 64'd3);
        issue(32'hFFFFFFFF);
        idle();
        chk("illegal_b", 64'(il_b), 64'd1);
        chk("illegal_we", 64'(we_b), 64'd0);
        idle();
        chk("wrap_post", 64'(rc_b), 64'd0);

        // Reset mid-pipe
        issue(32'h00100293);
        issue(32'h008000EF);
        step(1'b1, 1'b1, 32'h00200393, 1'b0, 1'b0);
        zero_checks("rst_mid");
        issue(32'h00200393);
        idle();
        chk("post_rst_first", 64'(ov_a), 64'd1);
        drain();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:0] = opc_tab[$urandom_range(13, 0)];
            if ($urandom_range(7, 0) == 0) w[11:7] = 5'd0;
            step($urandom_range(60, 0) == 0, $urandom_range(3, 0) != 0, w,
                 $urandom_range(5, 0) == 0, $urandom_range(15, 0) == 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_wb_ctl_pipe
`default_nettype wire
